// File: rtl/tst_din_seq.sv
// tst_din_seq: AXI4-Stream test pattern source.
// Emits frames of FRAME_LEN beats whose data carries the completed-frame count
// and the sample index. A frame that has started is always finished
// (DRAIN) even after test_en drops.
module tst_din_seq #(
  parameter int FRAME_LEN  = 1024,
  parameter int DATA_WIDTH = 64
) (
  input  logic                  ACLK,
  input  logic                  ARESETN,
  input  logic                  test_en,
  output logic [DATA_WIDTH-1:0] M_AXIS_TDATA,
  output logic                  M_AXIS_TVALID,
  input  logic                  M_AXIS_TREADY,
  output logic                  M_AXIS_TLAST,
  output logic [31:0]           itecnt,
  output logic                  busy
);

  localparam logic [15:0] LAST_IDX = 16'(FRAME_LEN - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t      state;
  logic [15:0] idx;
  logic [15:0] idx_next;
  logic [31:0] itecnt_q;
  logic        beat;
  logic [31:0] itecnt_sat;

  // Transfer qualifier, next sample index (wraps after the TLAST beat) and
  // saturating frame-count increment.
  always_comb begin
    beat       = M_AXIS_TVALID & M_AXIS_TREADY;
    idx_next   = M_AXIS_TLAST ? '0 : idx + 16'd1;
    itecnt_sat = (itecnt_q == '1) ? itecnt_q : itecnt_q + 32'd1;
  end

  // Frame sequencer; all stream outputs are registered here. TDATA/TLAST
  // derive only from idx/itecnt_q, which move solely on a transfer, so they
  // hold stable while the sink stalls.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state         <= IDLE;
      idx           <= '0;
      itecnt_q      <= '0;
      M_AXIS_TVALID <= 1'b0;
      M_AXIS_TLAST  <= 1'b0;
      busy          <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (test_en) begin
            state         <= RUN;
            idx           <= '0;
            itecnt_q      <= '0;
            M_AXIS_TVALID <= 1'b1;
            M_AXIS_TLAST  <= 1'b0;
            busy          <= 1'b1;
          end
        end
        RUN, DRAIN: begin
          if (beat) begin
            idx          <= idx_next;
            M_AXIS_TLAST <= (idx_next == LAST_IDX);
            if (M_AXIS_TLAST) itecnt_q <= itecnt_sat;
          end
          if (beat && M_AXIS_TLAST) begin
            if (state == RUN && test_en) begin
              state <= RUN;
            end else begin
              state         <= IDLE;
              M_AXIS_TVALID <= 1'b0;
              M_AXIS_TLAST  <= 1'b0;
              busy          <= 1'b0;
            end
          end else if (state == RUN && !test_en) begin
            state <= DRAIN;
          end
        end
        default: begin
          state         <= IDLE;
          M_AXIS_TVALID <= 1'b0;
          M_AXIS_TLAST  <= 1'b0;
          busy          <= 1'b0;
        end
      endcase
    end
  end

  assign itecnt       = itecnt_q;
  assign M_AXIS_TDATA = {itecnt_q, 16'd0, idx};

endmodule

// File: tb/tb_tst_din_seq.sv
// tb_tst_din_seq: directed vector bench for tst_din_seq with FRAME_LEN=4.
module tb_tst_din_seq;

  logic        ACLK = 1'b0;
  logic        ARESETN;
  logic        test_en;
  logic [63:0] M_AXIS_TDATA;
  logic        M_AXIS_TVALID;
  logic        M_AXIS_TREADY;
  logic        M_AXIS_TLAST;
  logic [31:0] itecnt;
  logic        busy;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  tst_din_seq #(.FRAME_LEN(4), .DATA_WIDTH(64)) dut (
    .ACLK          (ACLK),
    .ARESETN       (ARESETN),
    .test_en       (test_en),
    .M_AXIS_TDATA  (M_AXIS_TDATA),
    .M_AXIS_TVALID (M_AXIS_TVALID),
    .M_AXIS_TREADY (M_AXIS_TREADY),
    .M_AXIS_TLAST  (M_AXIS_TLAST),
    .itecnt        (itecnt),
    .busy          (busy)
  );

  always #5 ACLK = ~ACLK;

  typedef struct {
    logic        te;
    logic        tr;
    logic        valid;
    logic        last;
    logic [15:0] idx;
    logic [31:0] cnt;
    logic        bsy;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(logic te, logic tr, logic valid, logic last,
                              logic [15:0] idx, logic [31:0] cnt, logic bsy);
    vec_t v;
    v.te = te; v.tr = tr; v.valid = valid; v.last = last;
    v.idx = idx; v.cnt = cnt; v.bsy = bsy;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge ACLK);
    #1;
  endtask

  initial begin
    int unsigned tl_seen;
    int unsigned waited;

    // Frames of 4 beats, TREADY=1, 12 cycles of test_en then low.
    for (int k = 1; k <= 12; k++)
      add(1, 1, 1, ((k - 1) % 4) == 3, 16'((k - 1) % 4), 32'((k - 1) / 4), 1);
    add(0, 1, 0, 0, 0, 3, 0);
    add(0, 1, 0, 0, 0, 3, 0);
    // test_en drops after beat 1: beats 2,3 still emitted.
    add(1, 1, 1, 0, 0, 0, 1);
    add(1, 1, 1, 0, 1, 0, 1);
    add(0, 1, 1, 0, 2, 0, 1);
    add(0, 1, 1, 1, 3, 0, 1);
    add(0, 1, 0, 0, 0, 1, 0);
    // test_en re-asserted during DRAIN does not cancel; restart clears itecnt.
    add(1, 1, 1, 0, 0, 0, 1);
    add(0, 1, 1, 0, 1, 0, 1);
    add(1, 1, 1, 0, 2, 0, 1);
    add(1, 1, 1, 1, 3, 0, 1);
    add(1, 1, 0, 0, 0, 1, 0);
    add(1, 1, 1, 0, 0, 0, 1);
    add(0, 1, 1, 0, 1, 0, 1);
    add(0, 1, 1, 0, 2, 0, 1);
    add(0, 1, 1, 1, 3, 0, 1);
    add(0, 1, 0, 0, 0, 1, 0);
    // Back-pressure for 5 cycles on beat 2, and one stall on the TLAST beat.
    add(1, 1, 1, 0, 0, 0, 1);
    add(1, 1, 1, 0, 1, 0, 1);
    add(1, 1, 1, 0, 2, 0, 1);
    for (int k = 0; k < 5; k++) add(1, 0, 1, 0, 2, 0, 1);
    add(1, 1, 1, 1, 3, 0, 1);
    add(1, 0, 1, 1, 3, 0, 1);
    add(1, 1, 1, 0, 0, 1, 1);
    add(0, 1, 1, 0, 1, 1, 1);
    add(0, 1, 1, 0, 2, 1, 1);
    add(0, 1, 1, 1, 3, 1, 1);
    add(0, 1, 0, 0, 0, 2, 0);

    // Reset state.
    ARESETN = 1'b0;
    test_en = 1'b0;
    M_AXIS_TREADY = 1'b1;
    repeat (2) @(posedge ACLK);
    #1;
    chk("rst_tvalid", 64'(M_AXIS_TVALID), 64'd0);
    chk("rst_tlast",  64'(M_AXIS_TLAST),  64'd0);
    chk("rst_busy",   64'(busy),          64'd0);
    chk("rst_itecnt", 64'(itecnt),        64'd0);
    @(negedge ACLK);
    ARESETN = 1'b1;

    // Table-driven vectors.
    foreach (vecs[i]) begin
      @(negedge ACLK);
      test_en = vecs[i].te;
      M_AXIS_TREADY = vecs[i].tr;
      step();
      chk($sformatf("v%0d_tvalid", i), 64'(M_AXIS_TVALID), 64'(vecs[i].valid));
      chk($sformatf("v%0d_tlast", i),  64'(M_AXIS_TLAST),  64'(vecs[i].last));
      chk($sformatf("v%0d_busy", i),   64'(busy),          64'(vecs[i].bsy));
      chk($sformatf("v%0d_itecnt", i), 64'(itecnt),        64'(vecs[i].cnt));
      if (vecs[i].valid)
        chk($sformatf("v%0d_tdata", i), M_AXIS_TDATA, {vecs[i].cnt, 16'd0, vecs[i].idx});
    end

    // Run of 5 frames ends with itecnt=5, held in IDLE, cleared on restart.
    @(negedge ACLK);
    test_en = 1'b1;
    M_AXIS_TREADY = 1'b1;
    repeat (20) @(posedge ACLK);
    @(negedge ACLK);
    test_en = 1'b0;
    step();
    chk("five_itecnt", 64'(itecnt), 64'd5);
    chk("five_busy",   64'(busy),   64'd0);
    repeat (2) step();
    chk("idle_hold_itecnt", 64'(itecnt), 64'd5);
    @(negedge ACLK);
    test_en = 1'b1;
    step();
    chk("restart_itecnt", 64'(itecnt), 64'd0);
    chk("restart_tdata_hi", 64'(M_AXIS_TDATA[63:32]), 64'd0);
    chk("restart_tvalid", 64'(M_AXIS_TVALID), 64'd1);

    // Asynchronous reset mid-frame (frame 2, index 1).
    repeat (5) step();
    chk("pre_rst_itecnt", 64'(itecnt), 64'd1);
    chk("pre_rst_idx", 64'(M_AXIS_TDATA[15:0]), 64'd1);
    #2;
    ARESETN = 1'b0;
    #1;
    chk("arst_tvalid", 64'(M_AXIS_TVALID), 64'd0);
    chk("arst_busy",   64'(busy),          64'd0);
    chk("arst_itecnt", 64'(itecnt),        64'd0);
    chk("arst_tlast",  64'(M_AXIS_TLAST),  64'd0);
    tl_seen = 0;
    for (int k = 0; k < 6; k++) begin
      step();
      if (M_AXIS_TLAST || M_AXIS_TVALID) tl_seen++;
    end
    chk("arst_no_tlast", 64'(tl_seen), 64'd0);

    // First state change on the first edge with ARESETN high.
    @(negedge ACLK);
    ARESETN = 1'b1;
    #1;
    chk("rel_busy_before_edge", 64'(busy), 64'd0);
    step();
    chk("rel_busy", 64'(busy), 64'd1);
    chk("rel_tdata", M_AXIS_TDATA, 64'd0);

    // Saturation: itecnt preset to 0xFFFFFFFE mid-frame.
    @(negedge ACLK);
    force dut.itecnt_q = 32'hFFFF_FFFE;
    #1;
    release dut.itecnt_q;
    repeat (3) step();
    chk("sat_tlast1", 64'(M_AXIS_TLAST), 64'd1);
    chk("sat_tdata1", M_AXIS_TDATA, {32'hFFFF_FFFE, 16'd0, 16'd3});
    step();
    chk("sat_itecnt1", 64'(itecnt), 64'hFFFF_FFFF);
    repeat (3) step();
    chk("sat_tlast2", 64'(M_AXIS_TLAST), 64'd1);
    step();
    chk("sat_itecnt2", 64'(itecnt), 64'hFFFF_FFFF);
    @(negedge ACLK);
    test_en = 1'b0;
    waited = 0;
    while (busy && waited < 10) begin
      step();
      waited++;
    end
    chk("sat_drain_done", 64'(busy), 64'd0);
    chk("sat_itecnt_final", 64'(itecnt), 64'hFFFF_FFFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/tst_din_seq.md
TST_DIN_SEQ -- requirements
Module: tst_din_seq

Interface
REQ-001 Parameter FRAME_LEN, default 1024: samples per frame; legal range 2..65536.
REQ-002 Parameter DATA_WIDTH, fixed 64: stream data width.
REQ-003 ACLK  input  1  block clock; all state updates on rising edge.
REQ-004 ARESETN  input  1  asynchronous active-low reset.
REQ-005 test_en  input  1  test enable from the control register block; synchronous to ACLK.
REQ-006 M_AXIS_TDATA  output  64  test sample.
REQ-007 M_AXIS_TVALID  output  1  sample valid.
REQ-008 M_AXIS_TREADY  input  1  downstream ready.
REQ-009 M_AXIS_TLAST  output  1  last sample of frame.
REQ-010 itecnt  output  32  completed frame count, read back through the control registers.
REQ-011 busy  output  1  high while a frame is in progress.

Function
REQ-012 FSM states SHALL be IDLE, RUN and DRAIN.
REQ-013 IDLE -> RUN when test_en is high, entering with sample index 0.
REQ-014 On IDLE -> RUN the block SHALL clear itecnt to 0 on the same edge.
REQ-015 RUN: TVALID=1; a beat transfers on the edge where TVALID and TREADY are both high.
REQ-016 Each transferred beat SHALL increment the sample index; after beat FRAME_LEN-1 the index SHALL wrap to 0.
REQ-017 TDATA = {itecnt[31:0], 16'd0, sample index[15:0]}; TLAST = 1 iff index == FRAME_LEN-1.
REQ-018 While TVALID=1 and TREADY=0, TDATA and TLAST SHALL hold stable.
REQ-019 RUN -> DRAIN when test_en is sampled low and no TLAST beat transfers on that edge; a started frame is never truncated.
REQ-020 DRAIN: TVALID stays 1 and emission continues until the TLAST beat transfers, then -> IDLE.
REQ-021 The TLAST beat transfer SHALL increment itecnt, saturating at 0xFFFFFFFF.
REQ-022 TLAST beat transfer in RUN with test_en high: stay RUN, index 0, next frame back-to-back with no idle cycle.
REQ-023 TLAST beat transfer with test_en low (RUN or DRAIN): -> IDLE; TVALID=0 on the next cycle.
REQ-024 test_en re-asserted during DRAIN SHALL NOT cancel the drain; after IDLE the block restarts and clears itecnt.
REQ-025 busy = 1 in RUN and DRAIN, 0 in IDLE.
REQ-026 In IDLE: TVALID=0 and TLAST=0; TDATA is don't-care.
REQ-027 itecnt SHALL hold its value in IDLE.

Reset
REQ-028 With ARESETN low: state IDLE, sample index 0, itecnt 0, TVALID 0, TLAST 0, busy 0, all taking effect immediately and independent of ACLK.
REQ-029 Reset asserted mid-frame SHALL abort the frame with no TLAST emitted; itecnt SHALL NOT increment.
REQ-030 After ARESETN deasserts, the first state change SHALL occur on the first ACLK rising edge with ARESETN high.

Verification
REQ-031 FRAME_LEN=4, TREADY=1, test_en high for 12 cycles then low -> 3 frames with TDATA low halves 0,1,2,3 and TLAST on index 3; itecnt=3; busy then falls.
REQ-032 test_en drops after beat 1 of a FRAME_LEN=4 frame -> beats 2,3 still emitted with TLAST on 3; itecnt=1; then IDLE.
REQ-033 TREADY held low 5 cycles on beat 2 -> TVALID stays high and TDATA/TLAST stay constant; no beat is lost or duplicated.
REQ-034 ARESETN pulsed low asynchronously mid-frame -> TVALID, busy and itecnt go to 0 immediately; no TLAST occurs.
REQ-035 After a run ends with itecnt=5, test_en rises again -> itecnt reads 0, then the first frame carries itecnt=0 in TDATA[63:32].
REQ-036 itecnt forced to 0xFFFFFFFE, two further frames complete -> itecnt=0xFFFFFFFF, no wrap.
